// File: rtl/reg_file_block_pkg.sv
// Shared types and constants for the architectural register file.
package reg_file_block_pkg;

    localparam int ADDR_WIDTH       = 4;
    localparam int WORD_WIDTH       = 32;
    localparam int REG_FILE_SIZE    = 2 ** ADDR_WIDTH;
    localparam int DEFAULT_SP_INDEX = 13;

    typedef logic [WORD_WIDTH-1:0] WORD;

    // Write-back enable and branch request; both arrive already gated with valid.
    typedef logic reg_file_write_sig;
    typedef logic branch_from_wb;

    localparam reg_file_write_sig REG_FILE_WRITE_ENABLE = 1'b1;
    localparam branch_from_wb     BRANCH_TAKEN          = 1'b1;

    // The stack pointer is always word-aligned, so its low two bits are dropped.
    function automatic WORD align_sp_value(input WORD data);
        return {data[WORD_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port with write-through bypass from the write port.
module reg_file_read_port
    import reg_file_block_pkg::*;
(
    input  logic                  write_active,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WORD_WIDTH-1:0] write_value,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [WORD_WIDTH-1:0] stored_data,
    output logic [WORD_WIDTH-1:0] read_data
);

    // A same-cycle write to the addressed register wins over the stored copy.
    always_comb begin
        read_data = stored_data;
        if (write_active && (read_addr == write_addr)) begin
            read_data = write_value;
        end
    end

endmodule

// File: rtl/reg_file_block.sv
// Architectural register file: one write-back write port, three bypassed
// combinational read ports, and a registered PC redirect from write-back.
module reg_file_block
    import reg_file_block_pkg::*;
#(
    parameter int                    SP_INDEX = DEFAULT_SP_INDEX,
    parameter logic [WORD_WIDTH-1:0] SP_RESET = '0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_file_write_en_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic [WORD_WIDTH-1:0] reg_data_i,
    input  logic                  branch_from_wb_i,
    input  logic [WORD_WIDTH-1:0] program_counter_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_a_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_b_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_c_i,
    output logic [WORD_WIDTH-1:0] read_data_a_o,
    output logic [WORD_WIDTH-1:0] read_data_b_o,
    output logic [WORD_WIDTH-1:0] read_data_c_o,
    output logic                  pc_load_o,
    output logic [WORD_WIDTH-1:0] pc_target_o
);

    localparam logic [ADDR_WIDTH-1:0] SP_ADDR = ADDR_WIDTH'(SP_INDEX);

    logic [WORD_WIDTH-1:0] regs [REG_FILE_SIZE];
    logic                  write_active;
    logic [WORD_WIDTH-1:0] write_value;

    assign write_active = (reg_file_write_en_i == REG_FILE_WRITE_ENABLE);

    // Writes to the stack pointer are forced word-aligned before storage and bypass.
    always_comb begin
        write_value = reg_data_i;
        if (reg_dest_addr_i == SP_ADDR) begin
            write_value = align_sp_value(reg_data_i);
        end
    end

    // Register storage; reset clears everything except the stack pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else if (write_active) begin
            regs[reg_dest_addr_i] <= write_value;
        end
    end

    // Registered redirect: strobe follows each branch cycle, target holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_load_o   <= 1'b0;
            pc_target_o <= '0;
        end else begin
            pc_load_o <= (branch_from_wb_i == BRANCH_TAKEN);
            if (branch_from_wb_i == BRANCH_TAKEN) begin
                pc_target_o <= {program_counter_i[WORD_WIDTH-1:1], 1'b0};
            end
        end
    end

    reg_file_read_port u_read_port_a (
        .write_active (write_active),
        .write_addr   (reg_dest_addr_i),
        .write_value  (write_value),
        .read_addr    (read_addr_a_i),
        .stored_data  (regs[read_addr_a_i]),
        .read_data    (read_data_a_o)
    );

    reg_file_read_port u_read_port_b (
        .write_active (write_active),
        .write_addr   (reg_dest_addr_i),
        .write_value  (write_value),
        .read_addr    (read_addr_b_i),
        .stored_data  (regs[read_addr_b_i]),
        .read_data    (read_data_b_o)
    );

    reg_file_read_port u_read_port_c (
        .write_active (write_active),
        .write_addr   (reg_dest_addr_i),
        .write_value  (write_value),
        .read_addr    (read_addr_c_i),
        .stored_data  (regs[read_addr_c_i]),
        .read_data    (read_data_c_o)
    );

endmodule

// File: tb/tb_reg_file_block.sv
// Directed bench for reg_file_block with hand-computed expectations.
module tb_reg_file_block;

    logic        clk;
    logic        rst;
    logic        reg_file_write_en_i;
    logic [3:0]  reg_dest_addr_i;
    logic [31:0] reg_data_i;
    logic        branch_from_wb_i;
    logic [31:0] program_counter_i;
    logic [3:0]  read_addr_a_i;
    logic [3:0]  read_addr_b_i;
    logic [3:0]  read_addr_c_i;
    logic [31:0] read_data_a_o;
    logic [31:0] read_data_b_o;
    logic [31:0] read_data_c_o;
    logic        pc_load_o;
    logic [31:0] pc_target_o;

    int vectors;
    int miscompares;

    reg_file_block #(
        .SP_INDEX (13),
        .SP_RESET (32'h0000_1000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .reg_file_write_en_i (reg_file_write_en_i),
        .reg_dest_addr_i     (reg_dest_addr_i),
        .reg_data_i          (reg_data_i),
        .branch_from_wb_i    (branch_from_wb_i),
        .program_counter_i   (program_counter_i),
        .read_addr_a_i       (read_addr_a_i),
        .read_addr_b_i       (read_addr_b_i),
        .read_addr_c_i       (read_addr_c_i),
        .read_data_a_o       (read_data_a_o),
        .read_data_b_o       (read_data_b_o),
        .read_data_c_o       (read_data_c_o),
        .pc_load_o           (pc_load_o),
        .pc_target_o         (pc_target_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and leave a margin before inputs change or outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] expected;
        rst = 1'b1;
        reg_file_write_en_i = 1'b0;
        reg_dest_addr_i = '0;
        reg_data_i = '0;
        branch_from_wb_i = 1'b0;
        program_counter_i = '0;
        read_addr_a_i = '0;
        read_addr_b_i = '0;
        read_addr_c_i = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_addr_a_i = 4'(i);
            #1;
            expected = (i == 13) ? 32'h0000_1000 : 32'h0;
            vectors++;
            if (read_data_a_o !== expected) begin
                miscompares++;
                $display("[TB] FAIL reset_read r%0d: got %h expected %h", i, read_data_a_o, expected);
            end
        end
        vectors++;
        if (pc_load_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_pc_load: got %b expected 0", pc_load_o);
        end
        vectors++;
        if (pc_target_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_pc_target: got %h expected 0", pc_target_o);
        end
    endtask

    task automatic test_write_read();
        reg_file_write_en_i = 1'b1;
        reg_dest_addr_i = 4'd3;
        reg_data_i = 32'h0000_BEEF;
        read_addr_a_i = 4'd0;
        step();
        reg_file_write_en_i = 1'b0;
        read_addr_a_i = 4'd3;
        #1;
        vectors++;
        if (read_data_a_o !== 32'h0000_BEEF) begin
            miscompares++;
            $display("[TB] FAIL write_read r3: got %h expected 0000beef", read_data_a_o);
        end
        // Disabled write with a live value, then with X data: neither may land.
        reg_dest_addr_i = 4'd3;
        reg_data_i = 32'h0000_1234;
        read_addr_b_i = 4'd3;
        #1;
        vectors++;
        if (read_data_b_o !== 32'h0000_BEEF) begin
            miscompares++;
            $display("[TB] FAIL disabled_no_bypass: got %h expected 0000beef", read_data_b_o);
        end
        step();
        reg_data_i = 'x;
        step();
        vectors++;
        if (read_data_a_o !== 32'h0000_BEEF) begin
            miscompares++;
            $display("[TB] FAIL disabled_write r3: got %h expected 0000beef", read_data_a_o);
        end
        reg_data_i = '0;
    endtask

    task automatic test_bypass();
        reg_file_write_en_i = 1'b1;
        reg_dest_addr_i = 4'd5;
        reg_data_i = 32'h0000_A5A5;
        read_addr_a_i = 4'd5;
        read_addr_b_i = 4'd5;
        read_addr_c_i = 4'd5;
        #1;
        vectors++;
        if (read_data_a_o !== 32'h0000_A5A5) begin
            miscompares++;
            $display("[TB] FAIL bypass_a: got %h expected 0000a5a5", read_data_a_o);
        end
        vectors++;
        if (read_data_b_o !== 32'h0000_A5A5) begin
            miscompares++;
            $display("[TB] FAIL bypass_b: got %h expected 0000a5a5", read_data_b_o);
        end
        vectors++;
        if (read_data_c_o !== 32'h0000_A5A5) begin
            miscompares++;
            $display("[TB] FAIL bypass_c: got %h expected 0000a5a5", read_data_c_o);
        end
        read_addr_c_i = 4'd3;
        #1;
        vectors++;
        if (read_data_c_o !== 32'h0000_BEEF) begin
            miscompares++;
            $display("[TB] FAIL bypass_other_index: got %h expected 0000beef", read_data_c_o);
        end
        step();
        reg_file_write_en_i = 1'b0;
        #1;
        vectors++;
        if (read_data_a_o !== 32'h0000_A5A5) begin
            miscompares++;
            $display("[TB] FAIL stored_after_bypass r5: got %h expected 0000a5a5", read_data_a_o);
        end
    endtask

    task automatic test_sp_align();
        reg_file_write_en_i = 1'b1;
        reg_dest_addr_i = 4'd13;
        reg_data_i = 32'h0000_0FFF;
        read_addr_a_i = 4'd13;
        #1;
        vectors++;
        if (read_data_a_o !== 32'h0000_0FFC) begin
            miscompares++;
            $display("[TB] FAIL sp_bypass: got %h expected 00000ffc", read_data_a_o);
        end
        step();
        reg_file_write_en_i = 1'b0;
        #1;
        vectors++;
        if (read_data_a_o !== 32'h0000_0FFC) begin
            miscompares++;
            $display("[TB] FAIL sp_stored: got %h expected 00000ffc", read_data_a_o);
        end
        // A non-SP register keeps its low bits.
        reg_file_write_en_i = 1'b1;
        reg_dest_addr_i = 4'd6;
        reg_data_i = 32'h0000_0FFF;
        step();
        reg_file_write_en_i = 1'b0;
        read_addr_b_i = 4'd6;
        #1;
        vectors++;
        if (read_data_b_o !== 32'h0000_0FFF) begin
            miscompares++;
            $display("[TB] FAIL non_sp_unmasked r6: got %h expected 00000fff", read_data_b_o);
        end
    endtask

    task automatic test_back_to_back();
        branch_from_wb_i = 1'b1;
        program_counter_i = 32'h0000_0101;
        step();
        vectors++;
        if (pc_load_o !== 1'b1 || pc_target_o !== 32'h0000_0100) begin
            miscompares++;
            $display("[TB] FAIL branch_first: got load=%b target=%h expected load=1 target=00000100", pc_load_o, pc_target_o);
        end
        program_counter_i = 32'h0000_0200;
        step();
        vectors++;
        if (pc_load_o !== 1'b1 || pc_target_o !== 32'h0000_0200) begin
            miscompares++;
            $display("[TB] FAIL branch_second: got load=%b target=%h expected load=1 target=00000200", pc_load_o, pc_target_o);
        end
        branch_from_wb_i = 1'b0;
        program_counter_i = 32'h0000_3333;
        step();
        vectors++;
        if (pc_load_o !== 1'b0 || pc_target_o !== 32'h0000_0200) begin
            miscompares++;
            $display("[TB] FAIL branch_hold: got load=%b target=%h expected load=0 target=00000200", pc_load_o, pc_target_o);
        end
    endtask

    task automatic test_write_and_branch();
        reg_file_write_en_i = 1'b1;
        reg_dest_addr_i = 4'd7;
        reg_data_i = 32'h0000_0055;
        branch_from_wb_i = 1'b1;
        program_counter_i = 32'h0000_0045;
        step();
        reg_file_write_en_i = 1'b0;
        branch_from_wb_i = 1'b0;
        read_addr_c_i = 4'd7;
        #1;
        vectors++;
        if (pc_load_o !== 1'b1 || pc_target_o !== 32'h0000_0044) begin
            miscompares++;
            $display("[TB] FAIL write_branch_pc: got load=%b target=%h expected load=1 target=00000044", pc_load_o, pc_target_o);
        end
        vectors++;
        if (read_data_c_o !== 32'h0000_0055) begin
            miscompares++;
            $display("[TB] FAIL write_branch_reg r7: got %h expected 00000055", read_data_c_o);
        end
    endtask

    task automatic test_reset_override();
        rst = 1'b1;
        reg_file_write_en_i = 1'b1;
        reg_dest_addr_i = 4'd2;
        reg_data_i = 32'h0000_0007;
        branch_from_wb_i = 1'b1;
        program_counter_i = 32'h0000_0888;
        step();
        rst = 1'b0;
        reg_file_write_en_i = 1'b0;
        branch_from_wb_i = 1'b0;
        read_addr_a_i = 4'd2;
        read_addr_b_i = 4'd13;
        read_addr_c_i = 4'd5;
        #1;
        vectors++;
        if (read_data_a_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_override r2: got %h expected 0", read_data_a_o);
        end
        vectors++;
        if (read_data_b_o !== 32'h0000_1000 || read_data_c_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_override sp/r5: got %h/%h expected 00001000/0", read_data_b_o, read_data_c_o);
        end
        vectors++;
        if (pc_load_o !== 1'b0 || pc_target_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_override_pc: got load=%b target=%h expected load=0 target=0", pc_load_o, pc_target_o);
        end
        // First edge after reset processes a write normally.
        reg_file_write_en_i = 1'b1;
        reg_dest_addr_i = 4'd2;
        reg_data_i = 32'h0000_0009;
        step();
        reg_file_write_en_i = 1'b0;
        #1;
        vectors++;
        if (read_data_a_o !== 32'h0000_0009) begin
            miscompares++;
            $display("[TB] FAIL post_reset_write r2: got %h expected 00000009", read_data_a_o);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_sp_align();
        test_back_to_back();
        test_write_and_branch();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_block.md
# reg_file_block

Architectural register file that consumes the write-back stage outputs: one write port fed from write-back, three combinational read ports for decode/operand fetch, and a registered PC-redirect output driven by write-back branches. Same-cycle write/read hazards are resolved internally by write-through bypass, so decode never sees a stale value. It sits between the write-back block and the decode stage / PC-fetch logic.

## Interface
- SP_INDEX, 13: register index treated as stack pointer.
- SP_RESET, 'h0: reset value of the stack pointer; must be word-aligned.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- reg_file_write_en_i  in  reg_file_write_sig  write enable from write-back, already gated with valid.
- reg_dest_addr_i  in  ADDR_WIDTH  destination register index.
- reg_data_i  in  WORD  data to write.
- branch_from_wb_i  in  branch_from_wb  write-back branch request, already gated with valid.
- program_counter_i  in  WORD  branch target from write-back.
- read_addr_a_i / read_addr_b_i / read_addr_c_i  in  ADDR_WIDTH  read port indices (Rn, Rm, store data).
- read_data_a_o / read_data_b_o / read_data_c_o  out  WORD  read data.
- pc_load_o  out  1  one-cycle PC redirect strobe, registered.
- pc_target_o  out  WORD  redirect target, registered.

## Operation
- Storage: 2**ADDR_WIDTH registers of WORD bits.
- Write: when reg_file_write_en_i is the enabled value, register[reg_dest_addr_i] takes the write value at the next rising edge; otherwise no register changes.
- Write value: reg_data_i, except when reg_dest_addr_i == SP_INDEX, where bits [1:0] are forced to 0.
- Read: each port independently returns register[read_addr_x_i] combinationally.
- Bypass: if write enabled and read_addr_x_i == reg_dest_addr_i, port returns the write value (SP-masked if applicable) in the same cycle, not the stored value. All three ports may bypass simultaneously.
- Branch: when branch_from_wb_i is asserted, next edge sets pc_load_o=1 and pc_target_o = program_counter_i with bit 0 cleared. When deasserted, next edge sets pc_load_o=0; pc_target_o holds its last value.
- Write and branch in the same cycle are independent; both take effect.
- Write data is never X-propagated into storage when write is disabled; reg_data_i may be X then.

## Timing
- Reset (rst=1 at edge): all registers 0 except register[SP_INDEX]=SP_RESET; pc_load_o=0; pc_target_o=0. Reset overrides a simultaneous write or branch.
- Reads: zero latency (combinational from addresses, write inputs, and storage).
- Write: visible from storage one cycle after the write cycle; visible via bypass in the write cycle itself.
- Redirect: pc_load_o asserted exactly one cycle after each cycle with branch_from_wb_i asserted; back-to-back branch cycles produce back-to-back pulses, each with its own target.
- Reset deasserted mid-stream: first post-reset edge performs normal write/branch processing.

## Structure
- reg_file_write_sig, branch_from_wb, WORD, ADDR_WIDTH come from GENERAL_DEFS.svh; add REG_FILE_SIZE (=2**ADDR_WIDTH) and the default SP_INDEX constant there.
- One sub-module: reg_file_read_port (address compare + bypass mux), instantiated three times.

## Test plan
- Reset with SP_RESET='h1000, then read all indices -> all read 0, SP reads 'h1000, pc_load_o=0, pc_target_o=0.
- Write r3='hBEEF, next cycle read a=3 -> 'hBEEF; write with enable off to r3='h1234 -> r3 stays 'hBEEF.
- Write r5='hA5A5 while ports a,b,c all address r5 -> all three return 'hA5A5 in the same cycle; port returning stored value on other index unchanged.
- Write SP='h0FFF -> bypass and next-cycle read both 'h0FFC.
- branch_from_wb_i for two consecutive cycles with targets 'h0101, 'h0200 -> pc_load_o high two cycles, pc_target_o 'h0100 then 'h0200, then pc_load_o=0 with target held at 'h0200.
- rst asserted in same cycle as write r2='h7 and a branch -> r2 reads 0, pc_load_o=0 next cycle.
